// File: rtl/instr_fetch_seq.sv
// Program-memory fetch sequencer feeding the CPU datapath: holds a small loadable
// program and issues one instruction per cycle until a HALT word or end of memory.
module instr_fetch_seq #(
   parameter int IW    = 19,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic          stall,
   output logic [IW-1:0] instruction,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [2:0]    OP_HALT   = 3'b000;

   logic [IW-1:0] mem [DEPTH];

   state_t        state_reg;
   logic [IW-1:0] instr_reg;
   logic          valid_reg;
   logic [AW-1:0] pc_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          wrap_reg;

   logic [IW-1:0] fetch_word;
   logic          fetch_halt;
   logic          write_ok;

   assign fetch_word = mem[pc_reg];
   assign fetch_halt = (fetch_word[IW-1 -: 3] == OP_HALT);

   // The program is frozen while running; reset also blocks writes.
   assign write_ok = load_en && !rst && (state_reg != RUN);

   always_ff @(posedge clk) begin
      if (write_ok) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         instr_reg <= '0;
         valid_reg <= 1'b0;
         pc_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= RUN;
                  pc_reg    <= '0;
                  busy_reg  <= 1'b1;
                  wrap_reg  <= 1'b0;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (wrap_reg || fetch_halt) begin
                     // After the last address the pc has already wrapped; no fetch happens.
                     state_reg <= DONE;
                     instr_reg <= '0;
                     valid_reg <= 1'b0;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     wrap_reg  <= 1'b0;
                  end else begin
                     instr_reg <= fetch_word;
                     valid_reg <= 1'b1;
                     pc_reg    <= pc_reg + AW'(1);
                     wrap_reg  <= (pc_reg == LAST_ADDR);
                  end
               end
            end
            DONE: begin
               instr_reg <= '0;
               valid_reg <= 1'b0;
               if (start) begin
                  state_reg <= RUN;
                  pc_reg    <= '0;
                  busy_reg  <= 1'b1;
                  done_reg  <= 1'b0;
                  wrap_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               instr_reg <= '0;
               valid_reg <= 1'b0;
               pc_reg    <= '0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               wrap_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign instruction = instr_reg;
   assign instr_valid = valid_reg;
   assign pc          = pc_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: expected words are queued when a run is
// launched and checked against the DUT output on every falling edge.
module tb_instr_fetch_seq;

   localparam int IW    = 19;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [IW-1:0] load_data;
   logic          start;
   logic          stall;
   logic [IW-1:0] instruction;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          busy;
   logic          done;

   typedef struct packed {
      logic [IW-1:0] word;
      logic [AW-1:0] pc;
   } exp_t;

   exp_t          exp_q[$];
   logic [IW-1:0] model_mem [DEPTH];
   int            n_compared = 0;
   int            n_mismatch = 0;

   instr_fetch_seq #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .start       (start),
      .stall       (stall),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatch++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs are stable at the falling edge, so stall here is what the next edge sees.
   always @(negedge clk) begin
      if (!rst && instr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_valid", {31'd0, instr_valid}, 32'd0);
         end else begin
            $display("word %05h pc=%0d (expect %05h pc=%0d)", instruction, pc,
                     exp_q[0].word, exp_q[0].pc);
            check_eq("instruction", {13'd0, instruction}, {13'd0, exp_q[0].word});
            check_eq("pc_with_word", {28'd0, pc}, {28'd0, exp_q[0].pc});
            if (!stall) void'(exp_q.pop_front());
         end
      end
   end

   task automatic load_word(input int addr, input logic [IW-1:0] data);
      load_en   = 1'b1;
      load_addr = AW'(addr);
      load_data = data;
      tick();
      load_en = 1'b0;
      model_mem[addr] = data;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_instruction"}, {13'd0, instruction}, 32'd0);
      check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      check_eq({tag, "_pc"}, {28'd0, pc}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   // Launches a run from IDLE or DONE. Optional: stall on a word, a stray start
   // pulse mid-run, a reset abort at a given edge, or a held load_en to mem[3].
   task automatic run_program(input int stall_word, input int nstall, input int start_at,
                              input int abort_at, input logic hold_load,
                              input logic [IW-1:0] hold_data);
      int   n;
      int   edges;
      logic [AW-1:0] exp_pc;
      n = DEPTH;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (model_mem[i][IW-1 -: 3] == 3'b000) n = i;
      end
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{word: model_mem[i], pc: AW'(i + 1)});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("busy_after_start", {31'd0, busy}, 32'd1);
      check_eq("done_after_start", {31'd0, done}, 32'd0);
      check_eq("valid_after_start", {31'd0, instr_valid}, 32'd0);
      check_eq("pc_after_start", {28'd0, pc}, 32'd0);
      edges = 0;
      while (done !== 1'b1 && edges < 60) begin
         if (abort_at > 0 && edges == abort_at) begin
            check_eq("pc_before_abort", {28'd0, pc}, abort_at);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_outputs("abort");
            exp_q.delete();
            return;
         end
         start     = (edges == start_at);
         load_en   = hold_load && (edges <= n);
         load_addr = AW'(3);
         load_data = hold_data;
         if (edges == stall_word + 1 && nstall > 0) begin
            stall = 1'b1;
            for (int s = 0; s < nstall; s++) begin
               tick();
               start = 1'b0;
               check_eq("pc_during_stall", {28'd0, pc}, stall_word + 1);
            end
            stall = 1'b0;
         end
         tick();
         edges++;
      end
      start   = 1'b0;
      load_en = 1'b0;
      exp_pc  = (n == DEPTH) ? '0 : AW'(n);
      $display("run ended: n=%0d edges=%0d done=%0b pc=%0d", n, edges, done, pc);
      check_eq("edges_to_done", edges, n + 1);
      check_eq("done_final", {31'd0, done}, 32'd1);
      check_eq("busy_final", {31'd0, busy}, 32'd0);
      check_eq("valid_final", {31'd0, instr_valid}, 32'd0);
      check_eq("instruction_final", {13'd0, instruction}, 32'd0);
      check_eq("pc_final", {28'd0, pc}, {28'd0, exp_pc});
      check_eq("words_left", exp_q.size(), 0);
      exp_q.delete();
      tick();
      check_eq("no_extra_word", {31'd0, instr_valid}, 32'd0);
      check_eq("done_sticky", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [IW-1:0] w;
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Short program terminated by HALT at address 2.
      for (int i = 0; i < DEPTH; i++) load_word(i, '0);
      load_word(0, 19'b0010010001100010100);
      load_word(1, 19'b0100010001100010100);
      load_word(2, 19'b0000000000000000000);
      run_program(-1, 0, -1, 0, 1'b0, '0);

      // Restart from DONE with a 3-cycle stall on mem[1].
      run_program(1, 3, -1, 0, 1'b0, '0);

      // Full memory without HALT: ends by wrapping.
      for (int i = 0; i < DEPTH; i++) begin
         w = {3'((i % 7) + 1), 16'((i * 1234 + 77) & 16'hffff)};
         load_word(i, w);
      end
      run_program(-1, 0, -1, 0, 1'b0, '0);

      // Stray start mid-run is ignored.
      run_program(-1, 0, 7, 0, 1'b0, '0);

      // Reset while pc=5, then replay with memory intact.
      run_program(-1, 0, -1, 5, 1'b0, '0);
      tick();
      run_program(-1, 0, -1, 0, 1'b0, '0);

      // load_en during RUN is ignored; the same write from DONE lands.
      run_program(-1, 0, -1, 0, 1'b1, 19'b0000000000000000001);
      run_program(-1, 0, -1, 0, 1'b0, '0);
      load_word(3, 19'b0000000000000000001);
      run_program(-1, 0, -1, 0, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Sequencer stage directly upstream of the `CPU` datapath. It holds a small program of 19-bit instructions written through a load port. On `start`, it steps a program counter and presents one instruction per cycle on `instruction`, the CPU's input. It stops on a halt opcode or at the end of memory and reports completion.

## Interface
- `IW`, 19, instruction width; opcode is `[IW-1:IW-3]`.
- `DEPTH`, 16, number of program memory entries.
- `AW`, 4, address width; must satisfy 2^AW == DEPTH.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_en`  in  1  write `load_data` to `mem[load_addr]` this cycle.
- `load_addr`  in  AW  program write address.
- `load_data`  in  IW  program write data.
- `start`  in  1  begin execution from address 0.
- `stall`  in  1  freeze the fetch stage and hold all outputs.
- `instruction`  out  IW  instruction driven to the CPU.
- `instr_valid`  out  1  `instruction` carries a live program word.
- `pc`  out  AW  address of the next word to fetch.
- `busy`  out  1  state is RUN.
- `done`  out  1  program finished; sticky.

## Operation
- States: IDLE, RUN, DONE.
- Reset state: IDLE.
- Reset values of outputs: `instruction`=0, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0.
- Program memory is not cleared by reset.
- Opcode encoding:
  - 001 add, 010 sub, 011 and, 100 or, 101 not, 110 inc, 111 dec.
  - 000 is HALT and is never presented to the CPU.
- IDLE:
  - `load_en` writes the memory.
  - `start` sets `pc`<=0 and `busy`<=1, and moves to RUN.
  - `start` and `load_en` in the same cycle: the write occurs, then the move to RUN.
- RUN, `stall`=0, fetched word w = `mem[pc]`:
  - If opcode(w) != 000: `instruction`<=w, `instr_valid`<=1, `pc`<=`pc`+1.
    - If `pc`==DEPTH-1, this word is issued normally. On the following cycle the block moves to DONE, and `pc` wraps to 0 without fetching.
  - If opcode(w) == 000: `instruction`<=0, `instr_valid`<=0, `pc` holds, `busy`<=0, `done`<=1, and the block moves to DONE.
- RUN, `stall`=1: `instruction`, `instr_valid`, `pc` and state all hold.
- RUN: `load_en` and `start` are ignored.
- DONE:
  - `instruction`=0, `instr_valid`=0, `busy`=0, `done`=1.
  - `load_en` is honoured.
  - `start` clears `done`, sets `pc`<=0 and `busy`<=1, and moves to RUN (restart).
- `rst` overrides everything in any state, including mid-RUN; it returns the block to IDLE with reset values on the next edge.

## Timing
- `start` sampled at edge k:
  - `busy`=1 after edge k.
  - First word `mem[0]` appears on `instruction` after edge k+1, with `pc`=1.
- Steady state: one instruction per cycle. Each word is held exactly one cycle so the combinational CPU is sampled once per word.
- Stall:
  - Each stalled cycle adds one cycle to the hold time of the current word.
  - Stall asserted on the same edge as `start` does not delay the IDLE to RUN transition.
- HALT word at address n, no stalls:
  - `done`=1 after edge k+n+1.
  - Last valid instruction (address n-1) visible during cycle k+n.
- Full program with no HALT: DEPTH issued words, then `done`=1 one edge after the last word.
- Load write latency:
  - A word written at edge j is readable by a fetch at edge j+1.
  - A write to `mem[pc]` at the same edge as its fetch returns the old data.

## Test plan
- Reset, then load `mem[0]`=0010010001100010100, `mem[1]`=0100010001100010100, `mem[2]`=0000000000000000000, then pulse `start` -> the two words appear on consecutive cycles with `instr_valid`=1 and `pc`=1 then 2. Next cycle: `instr_valid`=0, `done`=1, `busy`=0, `pc`=2.
- Load all 16 entries with opcodes 001..111 (none 000) and run -> 16 consecutive valid words in address order, then `done`=1 with `pc`=0; no 17th word is issued.
- Assert `stall` for 3 cycles while `mem[1]` is presented -> `instruction` holds 0100010001100010100 for 4 cycles total; `pc` stays at 2 throughout, then the sequence resumes.
- Assert `rst` in RUN while `pc`=5 -> after the next edge all outputs are at reset values and the state is IDLE. A subsequent `start` re-runs from address 0 and memory contents are intact.
- In DONE, pulse `start` again -> `done` clears the same edge and the program replays identically. A `start` pulsed mid-RUN is ignored, with no change to `pc`.
- Hold `load_en`=1 while in RUN, writing `mem[3]` -> memory is unchanged; after DONE the same write takes effect and is observed on the next run.
